// File: rtl/silly_sweep_ctrl.sv
// silly_sweep_ctrl: self-test sequencer for the 3-input `silly` block.
// Steps {a,b,c} through 000..111, holds each vector DWELL+1 cycles,
// captures y/z at the end of the dwell and packs them into `results`
// (results[2i+1] = y, results[2i] = z for vector i).
// Optional golden-value checker enabled by defining SILLY_SWEEP_CHECK_EN;
// without it `mismatch` is constant 0 and EXP_Y/EXP_Z are unused.
module silly_sweep_ctrl #(
  parameter int unsigned DWELL = 2,      // 1..15
  parameter logic [7:0]  EXP_Y = 8'h00,
  parameter logic [7:0]  EXP_Z = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  input  logic        y,
  input  logic        z,
  output logic        busy,
  output logic        done,
  output logic [2:0]  idx,
  output logic [15:0] results,
  output logic        mismatch
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Dwell counter reload: DRIVE lasts DWELL cycles (cnt counts down to 0).
  localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [2:0]  idx_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [15:0] results_nxt;
  logic        mismatch_nxt;

  // The silly inputs are the index bits themselves, so they are registered
  // by construction and change exactly when idx does.
  assign a = idx[2];
  assign b = idx[1];
  assign c = idx[0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort only matters while a sweep is actually running.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (abort)         state_nxt = S_IDLE;
        else if (cnt == 4'd0) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)             state_nxt = S_IDLE;
        else if (idx == 3'd7)  state_nxt = S_DONE;
        else                   state_nxt = S_DRIVE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; everything is registered below so the
  // outputs never glitch with y/z.
  always_comb begin
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    results_nxt  = results;
    mismatch_nxt = mismatch;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt      = 3'd0;
          cnt_nxt      = CNT_LOAD;
          busy_nxt     = 1'b1;
          results_nxt  = 16'h0000;
          mismatch_nxt = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          idx_nxt  = 3'd0;
          busy_nxt = 1'b0;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          // The capture of an aborted SAMPLE cycle is dropped on purpose.
          idx_nxt  = 3'd0;
          busy_nxt = 1'b0;
        end else begin
          results_nxt[{idx, 1'b1}] = y;
          results_nxt[{idx, 1'b0}] = z;
`ifdef SILLY_SWEEP_CHECK_EN
          if ((y != EXP_Y[idx]) || (z != EXP_Z[idx])) mismatch_nxt = 1'b1;
`endif
          if (idx == 3'd7) begin
            idx_nxt  = 3'd0;
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
            cnt_nxt = CNT_LOAD;
          end
        end
      end
      S_DONE: begin
        idx_nxt = 3'd0;
      end
      default: begin
        idx_nxt  = 3'd0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset wins over start/abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= 3'd0;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      results <= 16'h0000;
    end else begin
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      results <= results_nxt;
    end
  end

`ifdef SILLY_SWEEP_CHECK_EN
  // Sticky golden-value mismatch flag, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) mismatch <= 1'b0;
    else       mismatch <= mismatch_nxt;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_silly_sweep_ctrl.sv
// Self-checking bench for silly_sweep_ctrl: a DWELL=2 and a DWELL=4 instance,
// each driving a table-based `silly` stub. Expected values come from
// cycle arithmetic on the sweep timeline and from the stub truth tables.
module tb_silly_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start2, abort2, start4, abort4;
  logic        a2, b2, c2, y2, z2, busy2, done2, mm2;
  logic        a4, b4, c4, y4, z4, busy4, done4, mm4;
  logic [2:0]  idx2, idx4;
  logic [15:0] res2, res4;
  logic [7:0]  ytab, ztab;

  localparam logic [7:0] GOLD_Y = 8'h96;
  localparam logic [7:0] GOLD_Z = 8'hEA;

  int errors = 0;
  int checks = 0;

  // silly stub: truth tables indexed by {a,b,c}
  assign y2 = ytab[{a2, b2, c2}];
  assign z2 = ztab[{a2, b2, c2}];
  assign y4 = ytab[{a4, b4, c4}];
  assign z4 = ztab[{a4, b4, c4}];

  silly_sweep_ctrl #(.DWELL(2), .EXP_Y(GOLD_Y), .EXP_Z(GOLD_Z)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .a(a2), .b(b2), .c(c2), .y(y2), .z(z2), .busy(busy2), .done(done2),
    .idx(idx2), .results(res2), .mismatch(mm2));

  silly_sweep_ctrl #(.DWELL(4), .EXP_Y(GOLD_Y), .EXP_Z(GOLD_Z)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(abort4),
    .a(a4), .b(b4), .c(c4), .y(y4), .z(z4), .busy(busy4), .done(done4),
    .idx(idx4), .results(res4), .mismatch(mm4));

  // Reference silly function: y = a^b^c, z = (a&b)|c
  function automatic logic [7:0] silly_ytab();
    logic [7:0] t;
    for (int v = 0; v < 8; v++) t[v] = ^v[2:0];
    return t;
  endfunction

  function automatic logic [7:0] silly_ztab();
    logic [7:0] t;
    logic [2:0] w;
    for (int v = 0; v < 8; v++) begin
      w = 3'(v);
      t[v] = (w[2] & w[1]) | w[0];
    end
    return t;
  endfunction

  // Results word after the first n vectors were captured
  function automatic logic [15:0] pack(input logic [7:0] ty, input logic [7:0] tz, input int n);
    logic [15:0] r = 16'h0000;
    for (int i = 0; i < n; i++) begin
      r[2*i+1] = ty[i];
      r[2*i]   = tz[i];
    end
    return r;
  endfunction

  function automatic logic exp_mm(input logic [7:0] ty, input logic [7:0] tz, input int n);
    logic m = 1'b0;
`ifdef SILLY_SWEEP_CHECK_EN
    for (int i = 0; i < n; i++)
      if (ty[i] != GOLD_Y[i] || tz[i] != GOLD_Z[i]) m = 1'b1;
`endif
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset busy/done got %b/%b want 0/0", busy2, done2); end
    checks++; if (idx2 !== 3'd0 || {a2, b2, c2} !== 3'd0) begin errors++; $display("FAIL reset idx/abc got %0d/%b want 0/000", idx2, {a2, b2, c2}); end
    checks++; if (res2 !== 16'h0000 || mm2 !== 1'b0) begin errors++; $display("FAIL reset results/mismatch got %h/%b want 0000/0", res2, mm2); end
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || idx4 !== 3'd0 || res4 !== 16'h0000 || mm4 !== 1'b0) begin
      errors++; $display("FAIL reset dut4 got busy=%b done=%b idx=%0d res=%h mm=%b want all 0", busy4, done4, idx4, res4, mm4); end
    reset = 1'b0;
    tick();
  endtask

  // One DWELL=2 sweep with optional abort cycle and extra start pulses
  // (cycle numbers count from 1 = first cycle after the start-sampling edge).
  task automatic sweep2(input string tag, input int abort_at, input int xs1, input int xs2);
    int         ndone = 0;
    int         ncap;
    logic       cut, eb, ed;
    logic [2:0] ei;
    cut  = (abort_at >= 1 && abort_at <= 24);
    ncap = cut ? (abort_at - 1) / 3 : 8;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++; if (res2 !== 16'h0000 || mm2 !== 1'b0) begin errors++; $display("FAIL %s start-clear got res=%h mm=%b want 0000/0", tag, res2, mm2); end
    for (int k = 1; k <= 27; k++) begin
      eb = !(cut && k > abort_at) && k <= 24;
      ed = !cut && k == 25;
      ei = eb ? 3'((k - 1) / 3) : 3'd0;
      checks++; if (busy2 !== eb) begin errors++; $display("FAIL %s busy cycle %0d got %b want %b", tag, k, busy2, eb); end
      checks++; if (done2 !== ed) begin errors++; $display("FAIL %s done cycle %0d got %b want %b", tag, k, done2, ed); end
      checks++; if (idx2 !== ei || {a2, b2, c2} !== ei) begin errors++; $display("FAIL %s idx/abc cycle %0d got %0d/%b want %0d", tag, k, idx2, {a2, b2, c2}, ei); end
      if (ed) begin
        checks++; if (res2 !== pack(ytab, ztab, 8) || mm2 !== exp_mm(ytab, ztab, 8)) begin
          errors++; $display("FAIL %s at-done got res=%h mm=%b want %h/%b", tag, res2, mm2, pack(ytab, ztab, 8), exp_mm(ytab, ztab, 8)); end
      end
      if (done2) ndone++;
      abort2 = (k == abort_at);
      start2 = (k == xs1 || k == xs2);
      tick();
    end
    abort2 = 1'b0;
    start2 = 1'b0;
    checks++; if (ndone != (cut ? 0 : 1)) begin errors++; $display("FAIL %s done-count got %0d want %0d", tag, ndone, cut ? 0 : 1); end
    checks++; if (res2 !== pack(ytab, ztab, ncap)) begin errors++; $display("FAIL %s results got %h want %h", tag, res2, pack(ytab, ztab, ncap)); end
    checks++; if (mm2 !== exp_mm(ytab, ztab, ncap)) begin errors++; $display("FAIL %s mismatch got %b want %b", tag, mm2, exp_mm(ytab, ztab, ncap)); end
  endtask

  task automatic test_basic();
    ytab = silly_ytab();
    ztab = silly_ztab();
    sweep2("basic", 0, 0, 0);
    checks++; if (res2 !== 16'hD66C) begin errors++; $display("FAIL basic-const results got %h want d66c", res2); end
  endtask

  task automatic test_dwell4();
    logic       eb, ed;
    logic [2:0] ei;
    int         ndone = 0;
    ytab = silly_ytab();
    ztab = silly_ztab();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      eb = k <= 40;
      ed = k == 41;
      ei = eb ? 3'((k - 1) / 5) : 3'd0;
      checks++; if (busy4 !== eb || done4 !== ed) begin errors++; $display("FAIL dwell4 busy/done cycle %0d got %b/%b want %b/%b", k, busy4, done4, eb, ed); end
      checks++; if ({a4, b4, c4} !== ei) begin errors++; $display("FAIL dwell4 abc cycle %0d got %b want %b", k, {a4, b4, c4}, ei); end
      if (done4) ndone++;
      tick();
    end
    checks++; if (ndone != 1 || res4 !== 16'hD66C) begin errors++; $display("FAIL dwell4 end got done=%0d res=%h want 1/d66c", ndone, res4); end
  endtask

  task automatic test_start_busy();
    ytab = silly_ytab();
    ztab = silly_ztab();
    sweep2("start_busy", 0, 3, 10);
    sweep2("start_in_done", 0, 25, 0);
    checks++; if (res2 !== 16'hD66C) begin errors++; $display("FAIL start_busy results got %h want d66c", res2); end
  endtask

  task automatic test_abort();
    ytab = silly_ytab();
    ztab = silly_ztab();
    sweep2("abort8", 8, 0, 0);
    checks++; if (res2 !== 16'h000C || idx2 !== 3'd0) begin errors++; $display("FAIL abort8 got res=%h idx=%0d want 000c/0", res2, idx2); end
    sweep2("abort_sample", 9, 0, 0);
    sweep2("abort_in_done", 25, 0, 0);
  endtask

  task automatic test_reset_mid();
    ytab = silly_ytab();
    ztab = silly_ztab();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 1; k < 12; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || idx2 !== 3'd0 || res2 !== 16'h0000 || mm2 !== 1'b0 || {a2, b2, c2} !== 3'd0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b idx=%0d res=%h mm=%b want reset values", busy2, done2, idx2, res2, mm2); end
    sweep2("after_reset", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic eb, ed;
    ytab = silly_ytab();
    ztab = silly_ztab();
    start2 = 1'b1;
    tick();
    for (int k = 1; k <= 27; k++) begin
      eb = (k <= 24) || (k == 27);
      ed = (k == 25);
      checks++; if (busy2 !== eb || done2 !== ed) begin errors++; $display("FAIL b2b cycle %0d got busy=%b done=%b want %b/%b", k, busy2, done2, eb, ed); end
      tick();
    end
    start2 = 1'b0;
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    checks++; if (busy2 !== 1'b0 || idx2 !== 3'd0) begin errors++; $display("FAIL b2b abort got busy=%b idx=%0d want 0/0", busy2, idx2); end
    // start and abort together in IDLE: start is taken
    start2 = 1'b1;
    abort2 = 1'b1;
    tick();
    start2 = 1'b0;
    abort2 = 1'b0;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL start_vs_abort busy got %b want 1", busy2); end
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL start_vs_abort cleanup got busy=%b done=%b want 0/0", busy2, done2); end
    tick();
  endtask

  task automatic test_random();
    int ab, x1, x2;
    for (int n = 0; n < 8; n++) begin
      ytab = 8'($urandom);
      ztab = 8'($urandom);
      ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25));
      x1 = int'($urandom_range(2, 25));
      x2 = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 25));
      if (ab != 0 && x1 > ab) x1 = 0;
      if (ab != 0 && x2 > ab) x2 = 0;
      sweep2($sformatf("random%0d", n), ab, x1, x2);
    end
  endtask

  task automatic test_checker();
    ytab = silly_ytab();
    ztab = silly_ztab();
    sweep2("checker_good", 0, 0, 0);
    ztab[5] = 1'b0;
    sweep2("checker_fault", 0, 0, 0);
`ifdef SILLY_SWEEP_CHECK_EN
    checks++; if (mm2 !== 1'b1) begin errors++; $display("FAIL checker_fault mismatch got %b want 1", mm2); end
`else
    checks++; if (mm2 !== 1'b0) begin errors++; $display("FAIL checker_off mismatch got %b want 0", mm2); end
`endif
    ztab = silly_ztab();
    sweep2("checker_clear", 0, 0, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start2 = 1'b0;
    abort2 = 1'b0;
    start4 = 1'b0;
    abort4 = 1'b0;
    ytab   = 8'h00;
    ztab   = 8'h00;
    test_reset();
    test_basic();
    test_dwell4();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_checker();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
